mii_frame_gen: RTL

- Frame source for the 64-bit MII lane-based datapath. It sits directly upstream of the MII checker state machine and drives its ctrl/data bus.
- On a start request it emits one frame:
  - a start column;
  - LEN payload bytes with an incrementing pattern;
  - a terminate character in the lane after the last payload byte;
  - a programmable inter-packet gap of idle columns.
- Used as the stimulus/traffic stage for link bring-up and checker validation.

---
 rtl/mii_frame_gen.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mii_frame_gen.sv
// mii_frame_gen: frame source for the 64-bit MII lane-based datapath.
// Each accepted start request produces one frame:
//   - a start column;
//   - LEN payload bytes counting up from the seed;
//   - a terminate character in the lane after the last payload byte;
//   - IPG_COLS all-idle columns.
//
// Parameters:
//   DATA_WIDTH - bus width in bits (only 64 supported), lanes = DATA_WIDTH/8
//   IPG_COLS   - idle columns forced after each terminate column (0 allowed)
//   LEN_W      - width of the payload length input
//
// Ports:
//   clk           - clock
//   rst_n         - synchronous active-low reset
//   start_i       - frame request, sampled only while idle
//   len_i         - payload byte count, latched on start
//   seed_i        - first payload byte value, latched on start
//   err_inject_i  - (only with MII_GEN_ERR_INJECT_EN) latched on start;
//                   lane 0 of the column after the start column becomes ERROR
//   ctrl_out      - per-lane control flags (bit i covers data_out[8i+7:8i])
//   data_out      - MII data column, lane 0 in the LSB byte
//   busy_o        - high from start acceptance until the state returns to idle
//   done_o        - one-cycle pulse with the column carrying the terminate
//   frame_count_o - terminated frame count, wraps at 2^32
//
// Optional feature macro: MII_GEN_ERR_INJECT_EN (error injection).
module mii_frame_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int IPG_COLS   = 1,
  parameter int LEN_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [LEN_W-1:0]        len_i,
  input  logic [7:0]              seed_i,
`ifdef MII_GEN_ERR_INJECT_EN
  input  logic                    err_inject_i,
`endif
  output logic [DATA_WIDTH/8-1:0] ctrl_out,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [31:0]             frame_count_o
);

  localparam int unsigned LANES = DATA_WIDTH / 8;

  localparam logic [7:0] CH_IDLE  = 8'h07;
  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;
  localparam logic [7:0] CH_PRE   = 8'h55;
`ifdef MII_GEN_ERR_INJECT_EN
  localparam logic [7:0] CH_ERR   = 8'hFE;
`endif

  localparam logic [DATA_WIDTH-1:0] IDLE_COL  = {LANES{CH_IDLE}};
  localparam logic [DATA_WIDTH-1:0] START_COL = {{(LANES-1){CH_PRE}}, CH_START};
  localparam logic [DATA_WIDTH-1:0] TERM_COL  = {{(LANES-1){CH_IDLE}}, CH_TERM};
  localparam logic [LEN_W-1:0]      LANES_L   = LEN_W'(LANES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_TERM,
    S_IPG
  } state_e;

  state_e            state_q;
  logic [LEN_W-1:0]  rem_q;
  logic [7:0]        pat_q;
  logic [15:0]       gap_q;
`ifdef MII_GEN_ERR_INJECT_EN
  logic              err_q;
`endif

  logic [LANES-1:0]      col_ctrl_d;
  logic [DATA_WIDTH-1:0] col_data_d;

  // Column for PAYLOAD/TERM states. A payload column with rem >= lanes is
  // all data; otherwise data lanes are followed by TERM then IDLE.
  always_comb begin
    col_ctrl_d = '1;
    col_data_d = TERM_COL;
    if (state_q == S_PAYLOAD) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (rem_q > LEN_W'(i)) begin
          col_ctrl_d[i]        = 1'b0;
          col_data_d[8*i +: 8] = pat_q + 8'(i);
        end else if (rem_q == LEN_W'(i)) begin
          col_ctrl_d[i]        = 1'b1;
          col_data_d[8*i +: 8] = CH_TERM;
        end else begin
          col_ctrl_d[i]        = 1'b1;
          col_data_d[8*i +: 8] = CH_IDLE;
        end
      end
    end
`ifdef MII_GEN_ERR_INJECT_EN
    // err_q is only ever set for the first column after the start column.
    if (err_q) begin
      col_ctrl_d[0]   = 1'b1;
      col_data_d[7:0] = CH_ERR;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rem_q         <= '0;
      pat_q         <= '0;
      gap_q         <= '0;
      ctrl_out      <= '1;
      data_out      <= IDLE_COL;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      frame_count_o <= '0;
`ifdef MII_GEN_ERR_INJECT_EN
      err_q         <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ctrl_out <= '1;
          data_out <= IDLE_COL;
          if (start_i) begin
            ctrl_out <= LANES'(1);
            data_out <= START_COL;
            rem_q    <= len_i;
            pat_q    <= seed_i;
            busy_o   <= 1'b1;
`ifdef MII_GEN_ERR_INJECT_EN
            err_q    <= err_inject_i;
`endif
            state_q  <= (len_i != '0) ? S_PAYLOAD : S_TERM;
          end
        end
        S_PAYLOAD, S_TERM: begin
          ctrl_out <= col_ctrl_d;
          data_out <= col_data_d;
`ifdef MII_GEN_ERR_INJECT_EN
          err_q    <= 1'b0;
`endif
          if (state_q == S_PAYLOAD && rem_q > LANES_L) begin
            rem_q <= rem_q - LANES_L;
            pat_q <= pat_q + 8'(LANES);
          end else if (state_q == S_PAYLOAD && rem_q == LANES_L) begin
            state_q <= S_TERM;
          end else begin
            // Terminate column: either TERM state or a partial payload column.
            done_o        <= 1'b1;
            frame_count_o <= frame_count_o + 32'd1;
            if (IPG_COLS == 0) begin
              state_q <= S_IDLE;
              busy_o  <= 1'b0;
            end else begin
              state_q <= S_IPG;
              gap_q   <= 16'(IPG_COLS);
            end
          end
        end
        S_IPG: begin
          ctrl_out <= '1;
          data_out <= IDLE_COL;
          if (gap_q <= 16'd1) begin
            state_q <= S_IDLE;
            busy_o  <= 1'b0;
          end else begin
            gap_q <= gap_q - 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
